cb_config_loader: RTL and testbench

//  Loads the configuration vector that drives the connection block switch controls (c).

---
 rtl/cb_config_loader.sv | 104 ++++++++++
 tb/tb_cb_config_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cb_config_loader.sv
// Stages a streamed config vector in a shadow register, verifies a trailing XOR checksum, then commits it to c atomically.
// Latency: NWORDS+1 transfer cycles, then c/done update on the edge after the checksum transfer.
// Backpressure: cfg_ready is high in LOAD/CHECK unless abort is asserted; no bubbles inserted when cfg_valid stays high.
module cb_config_loader #(
    parameter int CFG_BITS = 248,
    parameter int WORD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WORD_W-1:0]   cfg_word,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [CFG_BITS-1:0] c,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int NWORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   csum;
    logic [CFG_BITS-1:0] shadow;
    logic                xfer;
    logic                wr_load;

    assign cfg_ready = ((state == LOAD) || (state == CHECK)) && !abort;
    assign xfer      = cfg_valid && cfg_ready;
    assign wr_load   = xfer && (state == LOAD);
    assign busy      = (state != IDLE);

    // One register per payload word; the last word keeps only the bits that fit in CFG_BITS.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        localparam int LO = w * WORD_W;
        localparam int BW = ((CFG_BITS - LO) < WORD_W) ? (CFG_BITS - LO) : WORD_W;
        logic [BW-1:0] q;
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (wr_load && (cnt == CNT_W'(w))) begin
                q <= cfg_word[BW-1:0];
            end
        end
        assign shadow[LO +: BW] = q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            csum  <= '0;
            c     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= LOAD;
                        cnt   <= '0;
                        csum  <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        csum <= csum ^ cfg_word;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_W'(NWORDS - 1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        if (cfg_word == csum) begin
                            state <= COMMIT;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    // abort is deliberately ignored here so a verified pattern always lands.
                    c     <= shadow;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader: table of load scenarios plus hand-written corner sequences.
module tb_cb_config_loader;
    localparam int NW = 31;

    logic         clk = 1'b0;
    logic         rst, start, abort, cfg_valid, cfg_ready, busy, done, err;
    logic [7:0]   cfg_word;
    logic [247:0] c;

    logic         start16, abort16, valid16, ready16, busy16, done16, err16;
    logic [15:0]  word16;
    logic [247:0] c16;

    int n_tests = 0;
    int n_fail  = 0;
    logic [247:0] exp_c = '0;

    always #5 clk = ~clk;

    cb_config_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .c(c), .busy(busy), .done(done), .err(err)
    );

    cb_config_loader #(.CFG_BITS(248), .WORD_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .abort(abort16),
        .cfg_word(word16), .cfg_valid(valid16), .cfg_ready(ready16),
        .c(c16), .busy(busy16), .done(done16), .err(err16)
    );

    typedef struct {
        string name;
        int    seed;
        bit    bad_csum;
        bit    gaps;
        int    abort_after;     // -1: none; NW: abort while presenting checksum
        bit    abort_in_commit;
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] word_of(input int k, input int seed);
        if (seed == 0) return 8'(k + 1);
        return 8'(k * 37 + seed * 11);
    endfunction

    task automatic run_load(input vec_t v);
        logic [7:0]   cs;
        logic [247:0] new_c;
        int           gap;
        cs = '0;
        new_c = '0;
        for (int k = 0; k < NW; k++) begin
            cs = cs ^ word_of(k, v.seed);
            new_c[k*8 +: 8] = word_of(k, v.seed);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({v.name, " busy_after_start"}, busy, 1'b1);
        chk({v.name, " ready_in_load"}, cfg_ready, 1'b1);
        for (int k = 0; k <= NW; k++) begin
            if (v.gaps) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    cfg_valid = 1'b0;
                    cfg_word  = 8'hEE;
                    tick();
                    chk({v.name, " busy_in_gap"}, busy, 1'b1);
                end
            end
            cfg_valid = 1'b1;
            cfg_word  = (k < NW) ? word_of(k, v.seed) : (v.bad_csum ? cs ^ 8'hFF : cs);
            if (v.abort_after == k) begin
                abort = 1'b1;
                #1;
                chk({v.name, " ready_low_on_abort"}, cfg_ready, 1'b0);
                tick();
                abort = 1'b0;
                cfg_valid = 1'b0;
                chk({v.name, " idle_after_abort"}, busy, 1'b0);
                chk({v.name, " c_kept_on_abort"}, c, exp_c);
                chk({v.name, " no_pulse_on_abort"}, {done, err}, 2'b00);
                tick();
                chk({v.name, " no_late_pulse"}, {done, err}, 2'b00);
                return;
            end
            tick();
        end
        cfg_valid = 1'b0;
        if (v.abort_in_commit) abort = 1'b1;
        chk({v.name, " err_after_csum"}, err, v.exp_err);
        chk({v.name, " c_unchanged_at_csum"}, c, exp_c);
        chk({v.name, " done_not_yet"}, done, 1'b0);
        if (!v.exp_done) begin
            chk({v.name, " idle_after_err"}, busy, 1'b0);
            tick();
            chk({v.name, " err_one_cycle"}, {done, err}, 2'b00);
            chk({v.name, " c_kept_after_err"}, c, exp_c);
            return;
        end
        chk({v.name, " ready_low_commit"}, cfg_ready, 1'b0);
        tick();
        abort = 1'b0;
        exp_c = new_c;
        chk({v.name, " done_pulse"}, {done, err}, 2'b10);
        chk({v.name, " c_committed"}, c, exp_c);
        chk({v.name, " idle_after_commit"}, busy, 1'b0);
        tick();
        chk({v.name, " done_one_cycle"}, done, 1'b0);
        chk({v.name, " c_stable"}, c, exp_c);
    endtask

    vec_t vecs[9];

    initial begin
        logic [15:0]  cs16;
        logic [247:0] exp16;
        int           n_ab;

        vecs[0] = '{"good_seq",        0, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum",        0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{"good_gaps",       3, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"abort_10",        5, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"good_after_abt",  5, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"abort_commit",    7, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{"bad_gaps",        9, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{"abort_0",         2, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{"abort_check",     4, 1'b0, 1'b0, NW, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 0; abort = 0; cfg_valid = 0; cfg_word = '0;
        start16 = 0; abort16 = 0; valid16 = 0; word16 = '0;
        tick();
        tick();
        chk("reset_c", c, '0);
        chk("reset_flags", {busy, cfg_ready, done, err}, 4'b0000);
        rst = 1'b0;
        tick();

        // start together with abort must not leave IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, cfg_ready}, 2'b00);

        for (int i = 0; i < 9; i++) run_load(vecs[i]);

        // reset in the middle of a load clears everything, including c
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cfg_word = 8'(k + 100);
            tick();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_c = '0;
        chk("midload_rst_c", c, exp_c);
        chk("midload_rst_idle", busy, 1'b0);
        tick();

        // 16-bit words: last word truncated in c but checksummed in full
        cs16 = '0;
        exp16 = '0;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        valid16 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            word16 = (k == 15) ? 16'hAB12 : 16'(k + 1);
            cs16 = cs16 ^ word16;
            if (k < 15) exp16[k*16 +: 16] = word16;
            tick();
        end
        exp16[247:240] = 8'h12;
        word16 = cs16;
        tick();
        valid16 = 1'b0;
        chk("w16_no_err", err16, 1'b0);
        tick();
        chk("w16_done", done16, 1'b1);
        chk("w16_top_byte", c16[247:240], 8'h12);
        chk("w16_c", c16, exp16);
        n_ab = 0;
        for (int b = 0; b < 31; b++) if (c16[b*8 +: 8] == 8'hAB) n_ab++;
        chk("w16_no_AB", n_ab, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
